// File: rtl/i2c_slave_byte_engine_pkg.sv
// Shared types and constants for the I2C target byte engine.
package i2c_pkg;

    // Bus-protocol phase of the target engine
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_e;

    // 7-bit general-call address
    localparam logic [6:0] GCALL_ADDR = 7'h00;

    // Bit counter value of the last bit in a byte
    localparam logic [2:0] BIT_LAST = 3'd7;

endpackage

// File: rtl/i2c_slave_byte_engine_shift8.sv
// 8-bit MSB-first shift register with parallel load and a bit counter.
// 'full' rises on the eighth shift and holds until the next clear or load.
module i2c_shift8
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    input  logic       bit_in,
    output logic [7:0] data,
    output logic [2:0] bit_cnt,
    output logic       full
);

    logic [7:0] data_r;
    logic [2:0] bit_cnt_r;
    logic       full_r;

    // Clear has priority over load, load over shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r    <= 8'h00;
            bit_cnt_r <= 3'd0;
            full_r    <= 1'b0;
        end else if (clr) begin
            data_r    <= 8'h00;
            bit_cnt_r <= 3'd0;
            full_r    <= 1'b0;
        end else if (load) begin
            data_r    <= load_data;
            bit_cnt_r <= 3'd0;
            full_r    <= 1'b0;
        end else if (shift) begin
            data_r    <= {data_r[6:0], bit_in};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            full_r    <= full_r | (bit_cnt_r == BIT_LAST);
        end
    end

    assign data    = data_r;
    assign bit_cnt = bit_cnt_r;
    assign full    = full_r;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// Byte-level I2C target engine fed by the debounced SCL/SDA event stage.
// Transmit bytes reuse the receive shifter: each SCL rise shifts the bus bit
// in, which exposes the next bit to send at data[7] for the following fall.
module i2c_slave_byte_engine
    import i2c_pkg::*;
#(
    parameter bit         GCALL_EN     = 1'b0,
    parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] own_addr,
    input  logic       sta_det,
    input  logic       sto_det,
    input  logic       scl_rising,
    input  logic       scl_faling,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_nack,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       addressed,
    output logic       rw,
    output logic       gcall,
    output logic       tx_underrun,
    output logic       master_nack
);

    i2c_state_e state_r, state_s;
    logic       sda_r, sda_s;
    logic       addressed_r, addressed_s;
    logic       rw_r, rw_s;
    logic       gcall_r, gcall_s;
    logic [7:0] rx_data_r, rx_data_s;
    logic       rx_nack_r, rx_nack_s;
    logic       rx_valid_r, rx_valid_s;
    logic       tx_ack_r, tx_ack_s;
    logic       tx_underrun_r, tx_underrun_s;
    logic       master_nack_r, master_nack_s;
    logic       sh_clr_s, sh_load_s, sh_shift_s, sh_full_s, load_tx_s;
    logic [7:0] sh_load_data_s, sh_data_s, tx_byte_s;
    logic [2:0] sh_cnt_s;
    logic       addr_match_s, is_gcall_s;

    i2c_shift8 u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (sh_clr_s),
        .load      (sh_load_s),
        .load_data (sh_load_data_s),
        .shift     (sh_shift_s),
        .bit_in    (sda_i),
        .data      (sh_data_s),
        .bit_cnt   (sh_cnt_s),
        .full      (sh_full_s)
    );

    assign is_gcall_s   = GCALL_EN && (sh_data_s == {GCALL_ADDR, 1'b0});
    assign addr_match_s = (sh_data_s[7:1] == own_addr) || is_gcall_s;

    // Byte to load for transmission: fresh data or the idle filler
    always_comb begin
        if (tx_valid) begin
            tx_byte_s = tx_data;
        end else begin
            tx_byte_s = TX_IDLE_BYTE;
        end
    end

    // Next state, bus drive and pulses; enable, STOP and START outrank SCL edges
    always_comb begin
        state_s        = state_r;
        sda_s          = sda_r;
        addressed_s    = addressed_r;
        rw_s           = rw_r;
        gcall_s        = gcall_r;
        rx_data_s      = rx_data_r;
        rx_nack_s      = rx_nack_r;
        rx_valid_s     = 1'b0;
        tx_ack_s       = 1'b0;
        tx_underrun_s  = 1'b0;
        master_nack_s  = 1'b0;
        sh_clr_s       = 1'b0;
        sh_load_s      = 1'b0;
        sh_load_data_s = 8'h00;
        sh_shift_s     = 1'b0;
        load_tx_s      = 1'b0;
        if (!enable) begin
            state_s     = IDLE;
            sda_s       = 1'b1;
            addressed_s = 1'b0;
            sh_clr_s    = 1'b1;
        end else if (sto_det) begin
            state_s     = IDLE;
            sda_s       = 1'b1;
            addressed_s = 1'b0;
            sh_clr_s    = 1'b1;
        end else if (sta_det) begin
            state_s     = ADDR;
            sda_s       = 1'b1;
            addressed_s = 1'b0;
            sh_clr_s    = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_s = 1'b1;
                end
                ADDR: begin
                    if (scl_rising) begin
                        sh_shift_s = 1'b1;
                    end else if (scl_faling && sh_full_s) begin
                        sh_clr_s = 1'b1;
                        if (addr_match_s) begin
                            sda_s   = 1'b0;
                            rw_s    = sh_data_s[0];
                            gcall_s = is_gcall_s;
                            state_s = ADDR_ACK;
                        end else begin
                            sda_s   = 1'b1;
                            state_s = WAIT_STOP;
                        end
                    end else begin
                        sh_shift_s = 1'b0;
                    end
                end
                ADDR_ACK: begin
                    if (scl_faling) begin
                        addressed_s = 1'b1;
                        if (rw_r) begin
                            load_tx_s = 1'b1;
                            state_s   = TX;
                        end else begin
                            sda_s    = 1'b1;
                            sh_clr_s = 1'b1;
                            state_s  = RX;
                        end
                    end else begin
                        sh_shift_s = 1'b0;
                    end
                end
                RX: begin
                    if (scl_rising) begin
                        sh_shift_s = 1'b1;
                        if (sh_cnt_s == BIT_LAST) begin
                            rx_data_s  = {sh_data_s[6:0], sda_i};
                            rx_valid_s = 1'b1;
                            rx_nack_s  = rx_nack;
                        end else begin
                            rx_valid_s = 1'b0;
                        end
                    end else if (scl_faling && sh_full_s) begin
                        sda_s   = rx_nack_r;
                        state_s = RX_ACK;
                    end else begin
                        sh_shift_s = 1'b0;
                    end
                end
                RX_ACK: begin
                    if (scl_faling) begin
                        sda_s    = 1'b1;
                        sh_clr_s = 1'b1;
                        state_s  = RX;
                    end else begin
                        sh_clr_s = 1'b0;
                    end
                end
                TX: begin
                    if (scl_rising) begin
                        sh_shift_s = 1'b1;
                    end else if (scl_faling) begin
                        if (sh_full_s) begin
                            sda_s   = 1'b1;
                            state_s = TX_ACK;
                        end else begin
                            sda_s = sh_data_s[7];
                        end
                    end else begin
                        sh_shift_s = 1'b0;
                    end
                end
                TX_ACK: begin
                    if (scl_rising) begin
                        if (sda_i) begin
                            master_nack_s = 1'b1;
                            addressed_s   = 1'b0;
                            sda_s         = 1'b1;
                            state_s       = WAIT_STOP;
                        end else begin
                            master_nack_s = 1'b0;
                        end
                    end else if (scl_faling) begin
                        load_tx_s = 1'b1;
                        state_s   = TX;
                    end else begin
                        load_tx_s = 1'b0;
                    end
                end
                WAIT_STOP: begin
                    sda_s = 1'b1;
                end
                default: begin
                    state_s = IDLE;
                    sda_s   = 1'b1;
                end
            endcase
        end
        if (load_tx_s) begin
            sh_load_s      = 1'b1;
            sh_load_data_s = tx_byte_s;
            sda_s          = tx_byte_s[7];
            tx_ack_s       = tx_valid;
            tx_underrun_s  = !tx_valid;
        end else begin
            sh_load_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered bus drive, status and pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_r         <= 1'b1;
            addressed_r   <= 1'b0;
            rw_r          <= 1'b0;
            gcall_r       <= 1'b0;
            rx_data_r     <= 8'h00;
            rx_nack_r     <= 1'b0;
            rx_valid_r    <= 1'b0;
            tx_ack_r      <= 1'b0;
            tx_underrun_r <= 1'b0;
            master_nack_r <= 1'b0;
        end else begin
            sda_r         <= sda_s;
            addressed_r   <= addressed_s;
            rw_r          <= rw_s;
            gcall_r       <= gcall_s;
            rx_data_r     <= rx_data_s;
            rx_nack_r     <= rx_nack_s;
            rx_valid_r    <= rx_valid_s;
            tx_ack_r      <= tx_ack_s;
            tx_underrun_r <= tx_underrun_s;
            master_nack_r <= master_nack_s;
        end
    end

    assign sda_o       = sda_r;
    assign addressed   = addressed_r;
    assign rw          = rw_r;
    assign gcall       = gcall_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign tx_ack      = tx_ack_r;
    assign tx_underrun = tx_underrun_r;
    assign master_nack = master_nack_r;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Self-checking bench: the bench acts as I2C controller over the filtered
// event interface; a second instance with general call enabled shares inputs.
module tb_i2c_slave_byte_engine;
    import i2c_pkg::*;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, sta_det, sto_det, scl_rising, scl_faling, m_sda;
    logic       rx_nack, tx_valid;
    logic [6:0] own_addr;
    logic [7:0] tx_data;
    logic       sda_i, sda_o, rx_valid, tx_ack, addressed, rw, gcall, tx_underrun, master_nack;
    logic [7:0] rx_data;
    logic       sda_o_gc, rx_valid_gc, tx_ack_gc, addressed_gc, rw_gc, gcall_gc;
    logic       tx_underrun_gc, master_nack_gc;
    logic [7:0] rx_data_gc;

    // Open-drain bus: controller and main target wired-AND
    assign sda_i = m_sda & sda_o;

    i2c_slave_byte_engine #(.GCALL_EN(1'b0), .TX_IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .own_addr(own_addr),
        .sta_det(sta_det), .sto_det(sto_det), .scl_rising(scl_rising),
        .scl_faling(scl_faling), .sda_i(sda_i), .sda_o(sda_o),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_nack(rx_nack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
        .addressed(addressed), .rw(rw), .gcall(gcall),
        .tx_underrun(tx_underrun), .master_nack(master_nack)
    );

    i2c_slave_byte_engine #(.GCALL_EN(1'b1), .TX_IDLE_BYTE(8'hFF)) dut_gc (
        .clk(clk), .rst(rst), .enable(enable), .own_addr(own_addr),
        .sta_det(sta_det), .sto_det(sto_det), .scl_rising(scl_rising),
        .scl_faling(scl_faling), .sda_i(sda_i), .sda_o(sda_o_gc),
        .rx_data(rx_data_gc), .rx_valid(rx_valid_gc), .rx_nack(rx_nack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack_gc),
        .addressed(addressed_gc), .rw(rw_gc), .gcall(gcall_gc),
        .tx_underrun(tx_underrun_gc), .master_nack(master_nack_gc)
    );

    // Pulse monitors, sampled on the inactive edge
    int n_rx = 0, n_txack = 0, n_under = 0, n_mnack = 0;
    logic [7:0] rx_log [$];
    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx <= n_rx + 1;
            rx_log.push_back(rx_data);
        end
        if (tx_ack)      n_txack <= n_txack + 1;
        if (tx_underrun) n_under <= n_under + 1;
        if (master_nack) n_mnack <= n_mnack + 1;
    end

    int n_chk = 0, n_pass = 0;
    logic gc_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL clock; returns bus level and target drive while SCL is high
    task automatic clock_bit(input logic mb, output logic bus_bit, output logic slv_bit);
        m_sda = mb;
        tick(1);
        bus_bit = sda_i;
        slv_bit = sda_o;
        gc_bit  = sda_o_gc;
        scl_rising = 1'b1; tick(1); scl_rising = 1'b0; tick(2);
        scl_faling = 1'b1; tick(1); scl_faling = 1'b0; tick(2);
    endtask

    task automatic send_start();
        m_sda = 1'b1; tick(1);
        sta_det = 1'b1; tick(1); sta_det = 1'b0; m_sda = 1'b0; tick(1);
        scl_faling = 1'b1; tick(1); scl_faling = 1'b0; tick(2);
    endtask

    task automatic send_stop();
        m_sda = 1'b0; tick(1);
        sto_det = 1'b1; tick(1); sto_det = 1'b0; m_sda = 1'b1; tick(2);
    endtask

    // Write a byte; ack_bit is the target's drive during the ACK clock (0 = ACK)
    task automatic write_byte(input logic [7:0] b, output logic ack_bit);
        logic bb, sb;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], bb, sb);
        clock_bit(1'b1, bb, sb);
        ack_bit = sb;
    endtask

    // Read a byte; next tx byte is presented before the controller's ACK clock
    task automatic read_byte(input logic nv, input logic [7:0] nd, input logic mack,
                             output logic [7:0] b);
        logic bb, sb;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, bb, sb);
            b[i] = bb;
        end
        tx_valid = nv;
        tx_data  = nd;
        clock_bit(!mack, bb, sb);
    endtask

    // Reference rule for address acceptance
    function automatic logic model_ack(input logic [6:0] own, input logic [7:0] a, input bit gen);
        return (a[7:1] == own) || (gen && (a == 8'h00));
    endfunction

    task automatic run_write(input int idx, input logic [6:0] own, input logic [7:0] a,
                             input int n, input logic [23:0] dat, input logic [2:0] nmask,
                             input logic exp_ack, input int exp_rx);
        int   rx0, base;
        logic ab, db;
        logic [7:0] got;
        own_addr = own;
        rx0  = n_rx;
        base = rx_log.size();
        send_start();
        write_byte(a, ab);
        chk($sformatf("wr%0d_addr_ack", idx), 32'(ab), 32'(!exp_ack));
        chk($sformatf("wr%0d_addressed", idx), 32'(addressed), 32'(exp_ack));
        if (exp_ack) chk($sformatf("wr%0d_rw", idx), 32'(rw), 32'(1'b0));
        for (int k = 0; k < n; k++) begin
            rx_nack = nmask[k];
            write_byte(dat[k*8 +: 8], db);
            chk($sformatf("wr%0d_data_ack%0d", idx, k), 32'(db), 32'(exp_ack ? nmask[k] : 1'b1));
        end
        rx_nack = 1'b0;
        if (!exp_ack) chk($sformatf("wr%0d_wait_stop", idx), 32'(dut.state_r), 32'(WAIT_STOP));
        send_stop();
        chk($sformatf("wr%0d_addressed_stop", idx), 32'(addressed), 32'(1'b0));
        chk($sformatf("wr%0d_rx_count", idx), 32'(n_rx - rx0), 32'(exp_rx));
        if (exp_ack) begin
            for (int k = 0; k < n; k++) begin
                got = (base + k < rx_log.size()) ? rx_log[base + k] : 8'hXX;
                chk($sformatf("wr%0d_rx_data%0d", idx, k), 32'(got), 32'(dat[k*8 +: 8]));
            end
        end
    endtask

    task automatic run_read(input int idx, input logic [6:0] own, input logic [7:0] a,
                            input int n, input logic [23:0] dat, input logic [2:0] vmask,
                            input logic exp_ack);
        int   ta0, un0, mn0, n_ok;
        logic ab, nv;
        logic [7:0] got, nd, exp_b;
        own_addr = own;
        ta0 = n_txack; un0 = n_under; mn0 = n_mnack;
        tx_valid = vmask[0];
        tx_data  = dat[7:0];
        send_start();
        write_byte(a, ab);
        chk($sformatf("rd%0d_addr_ack", idx), 32'(ab), 32'(!exp_ack));
        n_ok = 0;
        if (exp_ack) begin
            chk($sformatf("rd%0d_rw", idx), 32'(rw), 32'(1'b1));
            for (int k = 0; k < n; k++) begin
                nv = (k + 1 < n) ? vmask[k + 1] : 1'b0;
                nd = (k + 1 < n) ? dat[(k + 1)*8 +: 8] : 8'h00;
                read_byte(nv, nd, (k != n - 1), got);
                exp_b = vmask[k] ? dat[k*8 +: 8] : IDLE_BYTE;
                if (vmask[k]) n_ok++;
                chk($sformatf("rd%0d_byte%0d", idx, k), 32'(got), 32'(exp_b));
            end
            chk($sformatf("rd%0d_addressed_nack", idx), 32'(addressed), 32'(1'b0));
        end
        send_stop();
        tx_valid = 1'b0;
        chk($sformatf("rd%0d_tx_ack_cnt", idx), 32'(n_txack - ta0), 32'(n_ok));
        chk($sformatf("rd%0d_underrun_cnt", idx), 32'(n_under - un0), 32'(exp_ack ? n - n_ok : 0));
        chk($sformatf("rd%0d_mnack_cnt", idx), 32'(n_mnack - mn0), 32'(exp_ack ? 1 : 0));
    endtask

    typedef struct {
        logic [6:0]  own;
        logic [7:0]  addr;
        int          n;
        logic [23:0] dat;
        logic [2:0]  nmask;
        logic        exp_ack;
        int          exp_rx;
    } wvec_t;

    wvec_t tbl [6];

    // Bound the run in case the design stalls the sequence
    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ab, bb, sb;
        logic [7:0] got;
        logic [6:0] r_own;
        logic [7:0] r_addr;
        logic [23:0] r_dat;
        logic [2:0] r_mask;
        int         r_n, rx0;

        tbl[0] = '{7'h50, 8'hA0, 1, 24'h00003C, 3'b000, 1'b1, 1};
        tbl[1] = '{7'h50, 8'hA2, 1, 24'h000055, 3'b000, 1'b0, 0};
        tbl[2] = '{7'h50, 8'hA0, 2, 24'h002211, 3'b010, 1'b1, 2};
        tbl[3] = '{7'h7F, 8'hFE, 3, 24'h81FF00, 3'b000, 1'b1, 3};
        tbl[4] = '{7'h2A, 8'h54, 1, 24'h0000A5, 3'b001, 1'b1, 1};
        tbl[5] = '{7'h2A, 8'h56, 2, 24'h001234, 3'b000, 1'b0, 0};

        rst = 1'b1; enable = 1'b1; sta_det = 1'b0; sto_det = 1'b0;
        scl_rising = 1'b0; scl_faling = 1'b0; m_sda = 1'b1;
        rx_nack = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; own_addr = 7'h50;
        tick(3);
        chk("rst_sda_o", 32'(sda_o), 32'(1'b1));
        chk("rst_rx_data", 32'(rx_data), 32'(8'h00));
        chk("rst_addressed", 32'(addressed), 32'(1'b0));
        chk("rst_rw", 32'(rw), 32'(1'b0));
        chk("rst_gcall", 32'(gcall), 32'(1'b0));
        chk("rst_pulses", 32'({rx_valid, tx_ack, tx_underrun, master_nack}), 32'(4'b0000));
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        rst = 1'b0;
        tick(2);

        // Table-driven write transfers
        for (int i = 0; i < 6; i++)
            run_write(i, tbl[i].own, tbl[i].addr, tbl[i].n, tbl[i].dat, tbl[i].nmask,
                      tbl[i].exp_ack, tbl[i].exp_rx);

        // Read: 0x96 supplied, then underrun filler, controller NACKs second byte
        run_read(100, 7'h50, 8'hA1, 2, 24'h000096, 3'b001, 1'b1);

        // Repeated START after four data bits, then a read
        own_addr = 7'h50;
        rx0 = n_rx;
        send_start();
        write_byte(8'hA0, ab);
        chk("rs_addr_ack", 32'(ab), 32'(1'b0));
        for (int i = 0; i < 4; i++) clock_bit(1'b0, bb, sb);
        tx_valid = 1'b1; tx_data = 8'h5B;
        send_start();
        write_byte(8'hA1, ab);
        chk("rs_read_ack", 32'(ab), 32'(1'b0));
        chk("rs_rw", 32'(rw), 32'(1'b1));
        read_byte(1'b0, 8'h00, 1'b0, got);
        chk("rs_byte", 32'(got), 32'(8'h5B));
        send_stop();
        chk("rs_no_partial_rx", 32'(n_rx - rx0), 32'(0));

        // General call: only the GCALL_EN=1 instance acknowledges
        send_start();
        write_byte(8'h00, ab);
        chk("gc_main_no_ack", 32'(ab), 32'(1'b1));
        chk("gc_inst_ack", 32'(gc_bit), 32'(1'b0));
        chk("gc_inst_gcall", 32'(gcall_gc), 32'(1'b1));
        chk("gc_main_gcall", 32'(gcall), 32'(1'b0));
        send_stop();

        // Asynchronous reset while the target pulls SDA low in TX
        tx_valid = 1'b1; tx_data = 8'h00;
        send_start();
        write_byte(8'hA1, ab);
        chk("rt_sda_low", 32'(sda_o), 32'(1'b0));
        #2 rst = 1'b1;
        #1;
        chk("rt_sda_release", 32'(sda_o), 32'(1'b1));
        chk("rt_state", 32'(dut.state_r), 32'(IDLE));
        chk("rt_addressed", 32'(addressed), 32'(1'b0));
        tick(1); rst = 1'b0; tick(1);

        // enable=0 mid-TX, then bits without START must be ignored
        send_start();
        write_byte(8'hA1, ab);
        chk("en_sda_low", 32'(sda_o), 32'(1'b0));
        enable = 1'b0;
        tick(1);
        chk("en_sda_release", 32'(sda_o), 32'(1'b1));
        chk("en_state", 32'(dut.state_r), 32'(IDLE));
        enable = 1'b1;
        tx_valid = 1'b0;
        write_byte(8'hA0, ab);
        chk("en_no_ack_without_start", 32'(ab), 32'(1'b1));
        send_stop();

        // Randomized transfers against the reference rules
        for (int i = 0; i < 24; i++) begin
            r_own  = 7'($urandom_range(0, 127));
            r_addr = ($urandom_range(0, 1) == 1) ? {r_own, 1'($urandom_range(0, 1))}
                                                 : 8'($urandom_range(0, 255));
            r_n    = $urandom_range(1, 3);
            r_dat  = 24'($urandom);
            r_mask = 3'($urandom_range(0, 7));
            if (r_addr[0] == 1'b0)
                run_write(200 + i, r_own, r_addr, r_n, r_dat, r_mask,
                          model_ack(r_own, r_addr, 1'b0),
                          model_ack(r_own, r_addr, 1'b0) ? r_n : 0);
            else
                run_read(200 + i, r_own, r_addr, r_n, r_dat, r_mask,
                         model_ack(r_own, r_addr, 1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
